demux_qam: RTL and testbench

DEMUX_QAM -- requirements
Module: demux_qam

---
 rtl/demux_qam.sv | 100 ++++++++++
 tb/tb_demux_qam.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/demux_qam.sv
// demux_qam: gathers NUM_INPUTS symbol words into one vector and offers it to the QPSK or QAM16 sorter path.
// Optional 16-bit accepted-vector counter on port frame_cnt when DEMUX_QAM_FRAME_CNT_EN is defined.
module demux_qam #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            din,
  input  logic                        din_valid,
  input  logic                        din_start,
  output logic                        din_ready,
  input  logic [1:0]                  M,
  output logic [NUM_INPUTS*WIDTH-1:0] x,
  output logic                        xQPSK_valid,
  output logic                        xQAM16_valid,
  input  logic                        xQPSK_ready,
  input  logic                        xQAM16_ready,
`ifdef DEMUX_QAM_FRAME_CNT_EN
  output logic [15:0]                 frame_cnt,
`endif
  output logic                        mode_err
);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [1:0]                  mode_q, mode_d;
  logic [NUM_INPUTS*WIDTH-1:0] data_q, data_d;
  logic                        qpsk_q, qpsk_d, qam_q, qam_d, err_q, err_d;
  logic                        xfer, start, last, done;
  assign din_ready = state_q != S_HOLD;
  assign xfer      = din_valid && din_ready;
  assign start     = xfer && din_start;
  assign last      = state_q == S_COLLECT && xfer && !din_start && cnt_q == CW'(NUM_INPUTS - 1);
  assign done      = (qpsk_q && xQPSK_ready) || (qam_q && xQAM16_ready);
  // Partial vectors are never exposed: x only carries data while a valid is up.
  assign x            = (qpsk_q || qam_q) ? data_q : '0;
  assign xQPSK_valid  = qpsk_q;
  assign xQAM16_valid = qam_q;
  assign mode_err     = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    qpsk_d  = qpsk_q;
    qam_d   = qam_q;
    err_d   = start && M[1];
    if (start) begin
      mode_d               = M;
      data_d[WIDTH-1:0]    = din;
      cnt_d                = CW'(1);
      state_d              = NUM_INPUTS == 1 ? S_HOLD : S_COLLECT;
      qpsk_d               = NUM_INPUTS == 1 && M == 2'b00;
      qam_d                = NUM_INPUTS == 1 && M != 2'b00;
    end else if (xfer && state_q == S_COLLECT) begin
      for (int k = 0; k < NUM_INPUTS; k++)
        if (cnt_q == CW'(k)) data_d[k*WIDTH +: WIDTH] = din;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? S_HOLD : S_COLLECT;
      qpsk_d  = last && mode_q == 2'b00;
      qam_d   = last && mode_q != 2'b00;
    end else if (state_q == S_HOLD && done) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      qpsk_d  = 1'b0;
      qam_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      data_q  <= '0;
      qpsk_q  <= 1'b0;
      qam_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      qpsk_q  <= qpsk_d;
      qam_q   <= qam_d;
      err_q   <= err_d;
    end
  end
`ifdef DEMUX_QAM_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else if (done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_demux_qam.sv
// tb_demux_qam: directed self-checking bench for demux_qam (WIDTH=8, NUM_INPUTS=4).
module tb_demux_qam;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid, din_start, din_ready;
  logic [1:0]  M;
  logic [31:0] x;
  logic        xQPSK_valid, xQAM16_valid, xQPSK_ready, xQAM16_ready, mode_err;
`ifdef DEMUX_QAM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  int n_assert = 0;
  int n_fail   = 0;

  demux_qam #(.WIDTH(8), .NUM_INPUTS(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_start(din_start),
    .din_ready(din_ready), .M(M), .x(x), .xQPSK_valid(xQPSK_valid), .xQAM16_valid(xQAM16_valid),
    .xQPSK_ready(xQPSK_ready), .xQAM16_ready(xQAM16_ready),
`ifdef DEMUX_QAM_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    din = d; din_valid = 1'b1; din_start = s;
    step();
    din_valid = 1'b0; din_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; din_start = 1'b0; M = 2'b00;
    xQPSK_ready = 1'b0; xQAM16_ready = 1'b0;
    step(); step();
    chk("rst_x", x, 32'h0);
    chk("rst_qpsk_valid", {31'b0, xQPSK_valid}, 32'h0);
    chk("rst_qam16_valid", {31'b0, xQAM16_valid}, 32'h0);
    chk("rst_mode_err", {31'b0, mode_err}, 32'h0);
    rst = 1'b0;
    step();
    chk("rst_din_ready", {31'b0, din_ready}, 32'h1);

    M = 2'b00; xQPSK_ready = 1'b1;
    send(8'h11, 1'b1);
    chk("qpsk_collect_ready", {31'b0, din_ready}, 32'h1);
    send(8'h22, 1'b0); send(8'h33, 1'b0);
    chk("qpsk_no_early_valid", {31'b0, xQPSK_valid}, 32'h0);
    send(8'h44, 1'b0);
    chk("qpsk_x", x, 32'h44332211);
    chk("qpsk_valid", {31'b0, xQPSK_valid}, 32'h1);
    chk("qpsk_other_valid", {31'b0, xQAM16_valid}, 32'h0);
    chk("qpsk_hold_ready", {31'b0, din_ready}, 32'h0);
    step();
    chk("qpsk_valid_drop", {31'b0, xQPSK_valid}, 32'h0);
    chk("qpsk_idle_ready", {31'b0, din_ready}, 32'h1);

    M = 2'b01; xQPSK_ready = 1'b0; xQAM16_ready = 1'b0;
    send(8'hA1, 1'b1);
    M = 2'b00;
    send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b0);
    xQPSK_ready = 1'b1;
    chk("qam16_valid", {31'b0, xQAM16_valid}, 32'h1);
    chk("qam16_other_valid", {31'b0, xQPSK_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("qam16_hold_valid", {31'b0, xQAM16_valid}, 32'h1);
      chk("qam16_hold_x", x, 32'hD4C3B2A1);
      chk("qam16_hold_din_ready", {31'b0, din_ready}, 32'h0);
    end
    xQAM16_ready = 1'b1;
    step();
    chk("qam16_valid_drop", {31'b0, xQAM16_valid}, 32'h0);
    chk("qam16_idle_ready", {31'b0, din_ready}, 32'h1);

    M = 2'b00;
    send(8'h55, 1'b1); send(8'hAA, 1'b0);
    chk("restart_no_valid", {31'b0, xQPSK_valid}, 32'h0);
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
    chk("restart_no_early_valid", {31'b0, xQPSK_valid}, 32'h0);
    send(8'h04, 1'b0);
    chk("restart_x", x, 32'h04030201);
    chk("restart_valid", {31'b0, xQPSK_valid}, 32'h1);
    step();
    chk("restart_single", {31'b0, xQPSK_valid}, 32'h0);

    M = 2'b11;
    send(8'h77, 1'b0); send(8'h78, 1'b0); step();
    chk("idle_discard_qpsk", {31'b0, xQPSK_valid}, 32'h0);
    chk("idle_discard_qam16", {31'b0, xQAM16_valid}, 32'h0);
    chk("idle_discard_err", {31'b0, mode_err}, 32'h0);
    send(8'h10, 1'b1);
    M = 2'b00;
    chk("m11_mode_err", {31'b0, mode_err}, 32'h1);
    send(8'h20, 1'b0);
    chk("m11_mode_err_pulse", {31'b0, mode_err}, 32'h0);
    send(8'h30, 1'b0); send(8'h40, 1'b0);
    chk("m11_x", x, 32'h40302010);
    chk("m11_qam16_valid", {31'b0, xQAM16_valid}, 32'h1);
    chk("m11_qpsk_valid", {31'b0, xQPSK_valid}, 32'h0);
    step();
    chk("m11_valid_drop", {31'b0, xQAM16_valid}, 32'h0);

    M = 2'b10;
    send(8'h99, 1'b1);
    chk("m10_mode_err", {31'b0, mode_err}, 32'h1);
    send(8'h98, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_x", x, 32'h0);
    chk("midrst_valids", {30'b0, xQPSK_valid, xQAM16_valid}, 32'h0);
    chk("midrst_mode_err", {31'b0, mode_err}, 32'h0);
    rst = 1'b0;
    M = 2'b00;
    send(8'h97, 1'b0); send(8'h96, 1'b0); step();
    chk("postrst_no_valid", {30'b0, xQPSK_valid, xQAM16_valid}, 32'h0);
    chk("postrst_din_ready", {31'b0, din_ready}, 32'h1);
    send(8'hEF, 1'b1); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'hDE, 1'b0);
    chk("postrst_x", x, 32'hDEADBEEF);
    chk("postrst_valid", {31'b0, xQPSK_valid}, 32'h1);
    step();
    chk("postrst_valid_drop", {31'b0, xQPSK_valid}, 32'h0);
`ifdef DEMUX_QAM_FRAME_CNT_EN
    chk("frame_cnt", {16'b0, frame_cnt}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
